// File: rtl/cbus_axil_bridge_pkg.sv
// Shared CBus register map and AXI response codes (the reg_define set) used by the bridge.
// addr_mapped() is the region decode applied when CBUS_DECERR_EN is defined.
package cbus_axil_bridge_pkg;

  localparam int unsigned CBUS_AW = 18;

  localparam logic [CBUS_AW-1:0] AXI2SREG_BASE  = 18'h00000;
  localparam logic [CBUS_AW-1:0] AD9361REG_BASE = 18'h00100;
  localparam logic [CBUS_AW-1:0] REGION_MASK    = 18'h3ff00;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_STB  = 3'd1,
    ST_WR_RSP  = 3'd2,
    ST_RD_STB  = 3'd3,
    ST_RD_WAIT = 3'd4,
    ST_RD_RSP  = 3'd5
  } state_e;

  typedef enum logic {
    PRIO_WR = 1'b0,
    PRIO_RD = 1'b1
  } prio_e;

  function automatic logic addr_mapped(input logic [CBUS_AW-1:0] waddr);
    logic [CBUS_AW-1:0] region;
    region = waddr & REGION_MASK;
    return (region == AXI2SREG_BASE) || (region == AD9361REG_BASE);
  endfunction

endpackage

// File: rtl/cbus_axil_bridge.sv
// AXI4-Lite slave to CBus initiator: one transaction at a time, single-cycle CBus strobe,
// fixed read latency. Optional address decode with SLVERR response under `CBUS_DECERR_EN`.
module cbus_axil_bridge
  import cbus_axil_bridge_pkg::*;
#(
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned AXI_AW     = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [AXI_AW-1:0] s_awaddr,
  input  logic              s_awvalid,
  output logic              s_awready,
  input  logic [31:0]       s_wdata,
  input  logic [3:0]        s_wstrb,
  input  logic              s_wvalid,
  output logic              s_wready,
  output logic [1:0]        s_bresp,
  output logic              s_bvalid,
  input  logic              s_bready,
  input  logic [AXI_AW-1:0] s_araddr,
  input  logic              s_arvalid,
  output logic              s_arready,
  output logic [31:0]       s_rdata,
  output logic [1:0]        s_rresp,
  output logic              s_rvalid,
  input  logic              s_rready,
  output logic [17:0]       cbus_addr,
  output logic [31:0]       cbus_din,
  output logic              cbus_wr,
  output logic              cbus_en,
  input  logic [31:0]       cbus_dout
);

  state_e              state_q, state_d;
  prio_e               prio_q, prio_d;
  logic                aw_held_q, aw_held_d;
  logic                w_held_q, w_held_d;
  logic [AXI_AW-1:0]   awaddr_q, awaddr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [CBUS_AW-1:0]  cbus_addr_q, cbus_addr_d;
  logic [31:0]         cbus_din_q, cbus_din_d;
  logic                cbus_wr_q, cbus_wr_d;
  logic                cbus_en_q, cbus_en_d;
  logic                err_q, err_d;
  logic [2:0]          cnt_q, cnt_d;
  logic                bvalid_q, bvalid_d;
  logic [1:0]          bresp_q, bresp_d;
  logic                rvalid_q, rvalid_d;
  logic [1:0]          rresp_q, rresp_d;
  logic [31:0]         rdata_q, rdata_d;

  logic                idle_s;
  logic                awready_s, wready_s, arready_s;
  logic                aw_hs_s, w_hs_s, ar_hs_s, wr_rdy_s;
  logic [AXI_AW-1:0]   wr_addr_s;
  logic [31:0]         wr_data_s;
  logic                wr_map_s, rd_map_s;
  logic                unused_s;

  // Readies are forced low while reset is asserted so nothing handshakes during reset.
  assign idle_s    = (state_q == ST_IDLE) && rst;
  assign awready_s = idle_s && !aw_held_q;
  assign wready_s  = idle_s && !w_held_q;
  assign aw_hs_s   = s_awvalid && awready_s;
  assign w_hs_s    = s_wvalid && wready_s;
  assign wr_rdy_s  = idle_s && (aw_held_q || aw_hs_s) && (w_held_q || w_hs_s);
  assign arready_s = wr_rdy_s ? (prio_q == PRIO_RD)
                              : (idle_s && !aw_held_q && !w_held_q && !aw_hs_s && !w_hs_s);
  assign ar_hs_s   = s_arvalid && arready_s;
  assign wr_addr_s = aw_hs_s ? s_awaddr : awaddr_q;
  assign wr_data_s = w_hs_s ? s_wdata : wdata_q;

`ifdef CBUS_DECERR_EN
  assign wr_map_s = addr_mapped(wr_addr_s[CBUS_AW+1:2]);
  assign rd_map_s = addr_mapped(s_araddr[CBUS_AW+1:2]);
`else
  assign wr_map_s = 1'b1;
  assign rd_map_s = 1'b1;
`endif

  // Strobes are full-word and byte lanes below bit 2 carry no CBus address.
  assign unused_s = ^{s_wstrb, s_araddr[1:0], wr_addr_s[1:0]};

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state, arbitration and datapath next values
  always_comb begin
    state_d     = state_q;
    prio_d      = prio_q;
    aw_held_d   = aw_held_q;
    w_held_d    = w_held_q;
    awaddr_d    = awaddr_q;
    wdata_d     = wdata_q;
    cbus_addr_d = cbus_addr_q;
    cbus_din_d  = cbus_din_q;
    cbus_wr_d   = 1'b0;
    cbus_en_d   = 1'b0;
    err_d       = err_q;
    cnt_d       = cnt_q;
    bvalid_d    = bvalid_q;
    bresp_d     = bresp_q;
    rvalid_d    = rvalid_q;
    rresp_d     = rresp_q;
    rdata_d     = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (aw_hs_s) begin
          aw_held_d = 1'b1;
          awaddr_d  = s_awaddr;
        end else begin
          aw_held_d = aw_held_q;
        end
        if (w_hs_s) begin
          w_held_d = 1'b1;
          wdata_d  = s_wdata;
        end else begin
          w_held_d = w_held_q;
        end
        // arready already encodes the priority decision, so an AR handshake is a read grant.
        if (ar_hs_s) begin
          state_d     = ST_RD_STB;
          prio_d      = (prio_q == PRIO_WR) ? PRIO_RD : PRIO_WR;
          cbus_addr_d = s_araddr[CBUS_AW+1:2];
          cbus_en_d   = rd_map_s;
          err_d       = !rd_map_s;
        end else if (wr_rdy_s) begin
          state_d     = ST_WR_STB;
          prio_d      = (prio_q == PRIO_WR) ? PRIO_RD : PRIO_WR;
          cbus_addr_d = wr_addr_s[CBUS_AW+1:2];
          cbus_din_d  = wr_data_s;
          cbus_wr_d   = wr_map_s;
          err_d       = !wr_map_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WR_STB: begin
        state_d  = ST_WR_RSP;
        bvalid_d = 1'b1;
        bresp_d  = err_q ? RESP_SLVERR : RESP_OKAY;
      end
      ST_WR_RSP: begin
        if (s_bready) begin
          state_d   = ST_IDLE;
          bvalid_d  = 1'b0;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
        end else begin
          state_d = ST_WR_RSP;
        end
      end
      ST_RD_STB: begin
        state_d = ST_RD_WAIT;
        cnt_d   = 3'(RD_LATENCY - 1);
      end
      ST_RD_WAIT: begin
        if (cnt_q == 3'd0) begin
          state_d  = ST_RD_RSP;
          rvalid_d = 1'b1;
          rdata_d  = err_q ? 32'h0000_0000 : cbus_dout;
          rresp_d  = err_q ? RESP_SLVERR : RESP_OKAY;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      ST_RD_RSP: begin
        if (s_rready) begin
          state_d  = ST_IDLE;
          rvalid_d = 1'b0;
        end else begin
          state_d = ST_RD_RSP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Hold flags, CBus drive registers and response registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prio_q      <= PRIO_WR;
      aw_held_q   <= 1'b0;
      w_held_q    <= 1'b0;
      awaddr_q    <= '0;
      wdata_q     <= 32'h0000_0000;
      cbus_addr_q <= 18'h00000;
      cbus_din_q  <= 32'h0000_0000;
      cbus_wr_q   <= 1'b0;
      cbus_en_q   <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= 3'd0;
      bvalid_q    <= 1'b0;
      bresp_q     <= RESP_OKAY;
      rvalid_q    <= 1'b0;
      rresp_q     <= RESP_OKAY;
      rdata_q     <= 32'h0000_0000;
    end else begin
      prio_q      <= prio_d;
      aw_held_q   <= aw_held_d;
      w_held_q    <= w_held_d;
      awaddr_q    <= awaddr_d;
      wdata_q     <= wdata_d;
      cbus_addr_q <= cbus_addr_d;
      cbus_din_q  <= cbus_din_d;
      cbus_wr_q   <= cbus_wr_d;
      cbus_en_q   <= cbus_en_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
      bvalid_q    <= bvalid_d;
      bresp_q     <= bresp_d;
      rvalid_q    <= rvalid_d;
      rresp_q     <= rresp_d;
      rdata_q     <= rdata_d;
    end
  end

  assign s_awready = awready_s;
  assign s_wready  = wready_s;
  assign s_arready = arready_s;
  assign s_bvalid  = bvalid_q;
  assign s_bresp   = bresp_q;
  assign s_rvalid  = rvalid_q;
  assign s_rresp   = rresp_q;
  assign s_rdata   = rdata_q;
  assign cbus_addr = cbus_addr_q;
  assign cbus_din  = cbus_din_q;
  assign cbus_wr   = cbus_wr_q;
  assign cbus_en   = cbus_en_q;

endmodule
